team_06_spi_frame_buffer: RTL and testbench

//  Downstream of the ESP serial-to-parallel stage; consumes its byte bus and level 'finished' flag.

---
 rtl/team_06_frame_pkg.sv | 24 ++
 rtl/team_06_spi_frame_buffer_if.sv | 25 ++
 rtl/team_06_commit_fifo.sv | 61 ++++++
 rtl/team_06_spi_frame_buffer.sv | 136 +++++++++++++
 tb/tb_team_06_spi_frame_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/team_06_frame_pkg.sv
// Shared types and defaults for the SPI frame buffer: FSM state encoding,
// default frame parameters and the pointer-width helper.
package team_06_frame_pkg;

  localparam int unsigned    DEFAULT_DEPTH     = 16;
  localparam int unsigned    DEFAULT_MAX_LEN   = 8;
  localparam logic [7:0]     DEFAULT_SYNC_BYTE = 8'hA5;

  // Pointers carry one extra bit so that full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/team_06_spi_frame_buffer_if.sv
// Byte-input and reader-side signals of the frame buffer; the slave modport
// is the buffer itself, the master modport is whoever feeds and drains it.
interface team_06_spi_frame_buffer_if;

  logic [7:0] byte_in;
  logic       byte_finished;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       frame_done;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  modport slave (
    input  byte_in, byte_finished, rd_en,
    output rd_data, empty, frame_done, frame_err, overflow, busy
  );

  modport master (
    output byte_in, byte_finished, rd_en,
    input  rd_data, empty, frame_done, frame_err, overflow, busy
  );

endinterface

// File: rtl/team_06_commit_fifo.sv
// FIFO with a speculative write pointer: pushes become visible to the reader
// only on commit, and rollback returns the write pointer to the last commit.
module team_06_commit_fifo
  import team_06_frame_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  input  logic                        commit,
  input  logic                        rollback,
  input  logic                        pop,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic [ptr_width(DEPTH)-1:0] count
);

  localparam int unsigned ADDR  = $clog2(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] commit_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because every pointer returns to zero on rst.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else if (rollback) begin
        wr_ptr <= commit_ptr;
      end
      if (commit) begin
        commit_ptr <= wr_ptr;
      end
      // A pop may coincide with commit/rollback: rd_ptr never exceeds commit_ptr.
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign empty   = (rd_ptr == commit_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr[ADDR-1:0]];

endmodule

// File: rtl/team_06_spi_frame_buffer.sv
// Parses [SYNC][LEN][PAYLOAD x LEN][CHK] frames from a deserializer byte bus
// and commits checksum-clean payloads into a fall-through FIFO for the reader.
module team_06_spi_frame_buffer
  import team_06_frame_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned MAX_LEN   = DEFAULT_MAX_LEN,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                       clk,
  input  logic                       rst,
  team_06_spi_frame_buffer_if.slave  bus
);

  localparam int unsigned PTR_W     = ptr_width(DEPTH);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

  state_t           state;
  logic             finished_d;
  logic             stb;
  logic [7:0]       sum;
  logic [7:0]       remain;
  logic [7:0]       chk_sum;
  logic             chk_ok;
  logic             full;
  logic [PTR_W-1:0] count;
  logic             push;
  logic             commit;
  logic             rollback;
  logic             frame_done;
  logic             frame_err;
  logic             overflow;

  assign stb     = bus.byte_finished & ~finished_d;
  assign chk_sum = sum + bus.byte_in;
  assign chk_ok  = (chk_sum == 8'h00);
  assign full    = (count == FULL_COUNT);

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (no latch).
  always_comb begin
    push     = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    if (stb) begin
      unique case (state)
        S_PAYLOAD: begin
          if (full) rollback = 1'b1;
          else      push     = 1'b1;
        end
        S_CHECK: begin
          if (chk_ok) commit   = 1'b1;
          else        rollback = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SYNC;
      finished_d <= 1'b0;
      sum        <= 8'h00;
      remain     <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      finished_d <= bus.byte_finished;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (stb) begin
        unique case (state)
          S_SYNC: begin
            if (bus.byte_in == SYNC_BYTE) state <= S_LEN;
          end
          S_LEN: begin
            if (bus.byte_in == 8'h00 || bus.byte_in > MAX_LEN_B) begin
              frame_err <= 1'b1;
              state     <= S_SYNC;
            end else begin
              remain <= bus.byte_in;
              sum    <= bus.byte_in;
              state  <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            remain <= remain - 8'd1;
            if (full) begin
              // Remaining payload and the CHK byte are swallowed in S_DISCARD.
              overflow  <= 1'b1;
              frame_err <= 1'b1;
              state     <= S_DISCARD;
            end else begin
              sum <= chk_sum;
              if (remain == 8'd1) state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (chk_ok) frame_done <= 1'b1;
            else        frame_err  <= 1'b1;
            state <= S_SYNC;
          end
          S_DISCARD: begin
            if (remain == 8'd0) state  <= S_SYNC;
            else                remain <= remain - 8'd1;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

  team_06_commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.byte_in),
    .commit    (commit),
    .rollback  (rollback),
    .pop       (bus.rd_en),
    .rd_data   (bus.rd_data),
    .empty     (bus.empty),
    .count     (count)
  );

  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
  assign bus.overflow   = overflow;
  assign bus.busy       = (state != S_SYNC);

endmodule

// File: tb/tb_team_06_spi_frame_buffer.sv
// Directed bench for the frame buffer: committed payloads are queued as
// expectations when frames are sent and compared as the reader pops them.
module tb_team_06_spi_frame_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  team_06_spi_frame_buffer_if bus ();

  team_06_spi_frame_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int d0, e0;
  logic [7:0] exp_q [$];
  logic [7:0] pl    [$];
  logic [7:0] chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every bench cycle passes through here, so pulse counts see every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.frame_err === 1'b1)  err_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in       = b;
    bus.byte_finished = 1'b1;
    tick();
    bus.byte_finished = 1'b0;
    tick();
  endtask

  // Sends LEN and the payload in pl; returns the checksum that makes the frame good.
  task automatic send_body(output logic [7:0] c);
    logic [7:0] s;
    s = 8'(pl.size());
    send_byte(s);
    foreach (pl[i]) begin
      send_byte(pl[i]);
      s = s + pl[i];
    end
    c = 8'h00 - s;
  endtask

  task automatic send_frame(input bit expect_ok);
    logic [7:0] c;
    send_byte(8'hA5);
    send_body(c);
    send_byte(c);
    if (expect_ok) foreach (pl[i]) exp_q.push_back(pl[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " empty"}, 32'(bus.empty), 0);
      check({tag, " data"}, 32'(bus.rd_data), 32'(exp_q.pop_front()));
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
    check({tag, " empty end"}, 32'(bus.empty), 1);
    check({tag, " rd_data end"}, 32'(bus.rd_data), 0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.byte_in       = 8'h00;
    bus.byte_finished = 1'b0;
    bus.rd_en         = 1'b0;
    tick();
    tick();
    check("rst empty", 32'(bus.empty), 1);
    check("rst rd_data", 32'(bus.rd_data), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst overflow", 32'(bus.overflow), 0);
    check("rst done", 32'(bus.frame_done), 0);
    check("rst err", 32'(bus.frame_err), 0);
    rst = 1'b0;
    tick();

    // 1: good frame, pulse timing checked around the CHK strobe
    d0 = done_cnt; e0 = err_cnt;
    pl = '{8'h11, 8'h22, 8'h33};
    send_byte(8'hA5);
    send_body(chk);
    check("t1 empty before chk", 32'(bus.empty), 1);
    bus.byte_in = chk; bus.byte_finished = 1'b1;
    tick();
    check("t1 done pulse", 32'(bus.frame_done), 1);
    bus.byte_finished = 1'b0;
    tick();
    check("t1 done one cycle", 32'(bus.frame_done), 0);
    check("t1 empty after", 32'(bus.empty), 0);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    check("t1 done count", 32'(done_cnt - d0), 1);
    check("t1 err count", 32'(err_cnt - e0), 0);
    drain("t1");

    // 2: bad checksum, then a good frame
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    check("t2 err count", 32'(err_cnt - e0), 1);
    check("t2 done count", 32'(done_cnt - d0), 0);
    check("t2 empty", 32'(bus.empty), 1);
    pl = '{8'h44, 8'h55};
    send_frame(1'b1);
    check("t2 recover done", 32'(done_cnt - d0), 1);
    drain("t2");

    // 3: illegal LEN values 0 and MAX_LEN+1
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    check("t3 len0 err", 32'(err_cnt - e0), 1);
    check("t3 len0 idle", 32'(bus.busy), 0);
    send_byte(8'hA5); send_byte(8'h09);
    check("t3 len9 err", 32'(err_cnt - e0), 2);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(1'b1);
    check("t3 max len done", 32'(done_cnt - d0), 1);
    drain("t3");

    // 5: noise before sync, and a long-held finished level counts once
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00); send_byte(8'h7F);
    check("t5 noise idle", 32'(bus.busy), 0);
    bus.byte_in = 8'hA5; bus.byte_finished = 1'b1;
    repeat (10) tick();
    bus.byte_finished = 1'b0;
    tick();
    check("t5 in len state", 32'(bus.busy), 1);
    pl = '{8'h66, 8'h77};
    send_body(chk);
    send_byte(chk);
    foreach (pl[i]) exp_q.push_back(pl[i]);
    check("t5 done count", 32'(done_cnt - d0), 1);
    check("t5 err count", 32'(err_cnt - e0), 0);
    drain("t5");

    // 4: fill all 16 entries, then a payload byte overflows
    pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    send_frame(1'b1);
    pl = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    send_frame(1'b1);
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    bus.byte_in = 8'h55; bus.byte_finished = 1'b1;
    tick();
    check("t4 err pulse", 32'(bus.frame_err), 1);
    check("t4 overflow", 32'(bus.overflow), 1);
    bus.byte_finished = 1'b0;
    tick();
    check("t4 discarding", 32'(bus.busy), 1);
    send_byte(8'hAB);
    check("t4 back to sync", 32'(bus.busy), 0);
    check("t4 err count", 32'(err_cnt - e0), 1);
    check("t4 done count", 32'(done_cnt - d0), 0);
    drain("t4");
    check("t4 overflow sticky", 32'(bus.overflow), 1);

    // 7: pop in the frame_done cycle and on the rollback edge
    pl = '{8'h01, 8'h02};
    send_frame(1'b1);
    pl = '{8'h03, 8'h04};
    send_byte(8'hA5);
    send_body(chk);
    bus.byte_in = chk; bus.byte_finished = 1'b1;
    tick();
    check("t7 done pulse", 32'(bus.frame_done), 1);
    check("t7 head at commit", 32'(bus.rd_data), 32'(exp_q[0]));
    bus.rd_en = 1'b1; bus.byte_finished = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    void'(exp_q.pop_front());
    foreach (pl[i]) exp_q.push_back(pl[i]);
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
    check("t7 head at rollback", 32'(bus.rd_data), 32'(exp_q[0]));
    bus.byte_in = 8'h00; bus.byte_finished = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.byte_finished = 1'b0;
    void'(exp_q.pop_front());
    check("t7 err pulse", 32'(bus.frame_err), 1);
    tick();
    check("t7 err count", 32'(err_cnt - e0), 1);
    drain("t7");

    // 6: reset mid-payload with committed data, and in the frame_done cycle
    pl = '{8'h0A, 8'h0B};
    send_frame(1'b1);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    tick();
    check("t6 mid empty", 32'(bus.empty), 1);
    check("t6 mid rd_data", 32'(bus.rd_data), 0);
    check("t6 mid busy", 32'(bus.busy), 0);
    check("t6 mid overflow", 32'(bus.overflow), 0);
    rst = 1'b0;
    exp_q.delete();
    tick();
    pl = '{8'h0C};
    send_byte(8'hA5);
    send_body(chk);
    bus.byte_in = chk; bus.byte_finished = 1'b1;
    tick();
    check("t6 done before rst", 32'(bus.frame_done), 1);
    rst = 1'b1; bus.byte_finished = 1'b0;
    tick();
    check("t6 done cleared", 32'(bus.frame_done), 0);
    check("t6 done-cycle empty", 32'(bus.empty), 1);
    check("t6 done-cycle busy", 32'(bus.busy), 0);
    rst = 1'b0;
    tick();
    d0 = done_cnt;
    pl = '{8'h5A, 8'hA5};
    send_frame(1'b1);
    check("t6 recover done", 32'(done_cnt - d0), 1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
